mfm_sync_byte_assembler: RTL and testbench
==========================================

// Module: mfm_sync_byte_assembler
// PURPOSE
//  Consumes the decoded MFM bit-pair stream (clock_bit/data_bit/bit_ready) from the MFM data sampler.
//  Hunts for the A1* sync mark (raw 0x4489, missing clock) and counts consecutive marks.
//  Captures the address-mark byte that follows, then frames data bytes for the sector/CRC stage.
//  Flags MFM encoding-rule violations for flux diagnostics.
// PARAMETERS
//  SYNC_PATTERN    16'h4489  raw clock/data pattern of one sync mark (MSB first)
//  MIN_SYNC_MARKS  3         consecutive sync marks needed before the mark byte is accepted (1..7)
// PORTS
//  clk             in   1  clock
//  reset           in   1  synchronous, active-high reset
//  enable          in   1  0 = force HUNT; input bits are ignored
//  resync          in   1  1-cycle pulse: abandon current frame, return to HUNT
//  pll_locked      in   1  DPLL lock status
//  bit_ready       in   1  1-cycle strobe; clock_bit/data_bit valid
//  clock_bit       in   1  MFM clock-cell bit
//  data_bit        in   1  MFM data-cell bit
//  byte_data       out  8  assembled byte, MSB first
//  byte_valid      out  1  1-cycle strobe; byte_data is a data byte
//  mark_valid      out  1  1-cycle strobe; byte_data is the address-mark byte (e.g. FE/FB)
//  in_frame        out  1  1 while state = DATA
//  sync_count      out  3  consecutive sync marks seen in the current hunt (saturates at 7)
//  code_violation  out  1  1-cycle strobe; MFM rule broken on this bit pair
//  viol_count      out  8  violations since reset (saturates at 255)
// BEHAVIOUR
//  Reset values: all outputs 0; state HUNT; raw_sr = 0; data_sr = 0; bit_cnt = 0.
//  On each bit_ready, next_raw = {raw_sr[13:0], clock_bit, data_bit} and data_sr shifts in data_bit.
//  The compare uses next_raw in the same cycle. Outputs are registered (1 cycle after bit_ready).
//  States:
//   - HUNT: on next_raw == SYNC_PATTERN -> SYNC; sync_count = 1; bit_cnt = 0.
//   - SYNC: bit_cnt counts bit_ready events 1..8. On the 8th:
//     - next_raw == SYNC_PATTERN -> sync_count += 1 (saturating), bit_cnt = 0.
//     - else if sync_count >= MIN_SYNC_MARKS -> byte_data = {data_sr[6:0], data_bit};
//       mark_valid pulses; go to DATA; bit_cnt = 0.
//     - else -> HUNT; sync_count = 0.
//   - DATA: every 8th bit_ready -> byte_data = {data_sr[6:0], data_bit}; byte_valid pulses.
//     Sync patterns are not checked in DATA.
//  Exit conditions:
//   - Exit to HUNT (sync_count, bit_cnt cleared) on: resync, enable = 0, or pll_locked = 0 while in SYNC/DATA.
//   - A partial byte in progress is discarded and not emitted.
//   - resync and bit_ready in the same cycle: resync wins and the bit is dropped; raw_sr and data_sr are cleared.
//  Violations, checked on every bit_ready while enable = 1, in any state:
//   - clock_bit & data_bit = 1, or
//   - clock_bit = 1 while the previous data_bit = 1.
//   - The missing-clock pattern of a sync mark is not a violation.
//   - viol_count increments on each violation and saturates at 255; it is cleared only by reset.
//  byte_valid and mark_valid are never high in the same cycle.
//  byte_data holds its value between strobes.
//  bit_ready gaps of any length are legal. bit_ready held high for consecutive cycles means one bit per cycle.
//  Reset mid-frame returns everything to the reset values on the next edge.
// TESTING
//  1. Send 12x pair 0x4E raw, 3x 0x4489, FE raw-encoded -> mark_valid=1, byte_data=8'hFE, sync_count=3, in_frame=1.
//  2. Continue with data 00 FF A5 -> 3 byte_valid strobes, byte_data 00/FF/A5, each exactly 8 bit_ready after the previous one.
//  3. Send only 2x 0x4489, then FE -> no mark_valid, state returns to HUNT, sync_count=0.
//  4. In DATA after 4 bits, drop pll_locked -> in_frame=0 next cycle, no byte_valid; a new 3x sync frames correctly.
//  5. Send clock=1,data=1 pair, then clock=1 after data=1 -> code_violation pulses twice, viol_count=2; sync 0x4489 gives 0.
//  6. Pulse resync together with bit_ready mid-mark -> HUNT, mark_valid stays 0, raw_sr cleared.

Source files
------------

// File: rtl/mfm_sync_byte_assembler.sv
// MFM sync-mark hunter and byte framer: finds A1* marks, captures the address-mark
// byte, frames data bytes and flags MFM encoding-rule violations.
module mfm_sync_byte_assembler #(
   parameter logic [15:0] SYNC_PATTERN   = 16'h4489,
   parameter int          MIN_SYNC_MARKS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       resync,
   input  logic       pll_locked,
   input  logic       bit_ready,
   input  logic       clock_bit,
   input  logic       data_bit,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       mark_valid,
   output logic       in_frame,
   output logic [2:0] sync_count,
   output logic       code_violation,
   output logic [7:0] viol_count
);

   typedef enum logic [1:0] {HUNT, SYNC, DATA} state_t;

   localparam logic [2:0] MIN_MARKS = 3'(MIN_SYNC_MARKS);

   state_t      state, state_nxt;
   // Only 14 bits of raw history and 7 data bits are ever needed to form the next compare/byte.
   logic [13:0] raw_sr, raw_nxt;
   logic [6:0]  data_sr, data_nxt;
   logic [3:0]  bit_cnt, cnt_nxt;
   logic [2:0]  sync_nxt;
   logic [7:0]  byte_nxt;
   logic        byte_v_nxt, mark_v_nxt, viol_nxt;
   logic [15:0] next_raw;
   logic        take_bit, is_sync, abort;

   assign next_raw = {raw_sr, clock_bit, data_bit};
   assign take_bit = enable && bit_ready && !resync;
   assign is_sync  = (next_raw == SYNC_PATTERN);
   assign abort    = !enable || resync || !pll_locked;
   assign in_frame = (state == DATA);

   always_comb begin
      state_nxt  = state;
      raw_nxt    = raw_sr;
      data_nxt   = data_sr;
      cnt_nxt    = bit_cnt;
      sync_nxt   = sync_count;
      byte_nxt   = byte_data;
      byte_v_nxt = 1'b0;
      mark_v_nxt = 1'b0;
      viol_nxt   = 1'b0;

      if (take_bit) begin
         raw_nxt  = next_raw[13:0];
         data_nxt = {data_sr[5:0], data_bit};
         // raw_sr[0] is the data bit of the previous pair.
         viol_nxt = clock_bit && (data_bit || raw_sr[0]);
      end
      if (resync) begin
         raw_nxt  = '0;
         data_nxt = '0;
      end

      if (abort) begin
         state_nxt = HUNT;
         sync_nxt  = 3'd0;
         cnt_nxt   = 4'd0;
      end else if (take_bit) begin
         case (state)
            HUNT: begin
               if (is_sync) begin
                  state_nxt = SYNC;
                  sync_nxt  = 3'd1;
                  cnt_nxt   = 4'd0;
               end
            end
            SYNC: begin
               if (bit_cnt == 4'd7) begin
                  cnt_nxt = 4'd0;
                  if (is_sync) begin
                     sync_nxt = (sync_count == 3'd7) ? 3'd7 : sync_count + 3'd1;
                  end else if (sync_count >= MIN_MARKS) begin
                     byte_nxt   = {data_sr, data_bit};
                     mark_v_nxt = 1'b1;
                     state_nxt  = DATA;
                  end else begin
                     state_nxt = HUNT;
                     sync_nxt  = 3'd0;
                  end
               end else begin
                  cnt_nxt = bit_cnt + 4'd1;
               end
            end
            DATA: begin
               if (bit_cnt == 4'd7) begin
                  cnt_nxt    = 4'd0;
                  byte_nxt   = {data_sr, data_bit};
                  byte_v_nxt = 1'b1;
               end else begin
                  cnt_nxt = bit_cnt + 4'd1;
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= HUNT;
         raw_sr         <= '0;
         data_sr        <= '0;
         bit_cnt        <= '0;
         sync_count     <= '0;
         byte_data      <= '0;
         byte_valid     <= 1'b0;
         mark_valid     <= 1'b0;
         code_violation <= 1'b0;
         viol_count     <= '0;
      end else begin
         state          <= state_nxt;
         raw_sr         <= raw_nxt;
         data_sr        <= data_nxt;
         bit_cnt        <= cnt_nxt;
         sync_count     <= sync_nxt;
         byte_data      <= byte_nxt;
         byte_valid     <= byte_v_nxt;
         mark_valid     <= mark_v_nxt;
         code_violation <= viol_nxt;
         if (viol_nxt && viol_count != 8'hFF) begin
            viol_count <= viol_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_mfm_sync_byte_assembler.sv
// Directed bench for mfm_sync_byte_assembler: MFM-encodes gap/sync/mark/data streams
// and checks framing, exits, violations and reset against hand-computed values.
module tb_mfm_sync_byte_assembler;

   logic       clk = 1'b0;
   logic       reset, enable, resync, pll_locked, bit_ready, clock_bit, data_bit;
   logic [7:0] byte_data, viol_count;
   logic       byte_valid, mark_valid, in_frame, code_violation;
   logic [2:0] sync_count;

   int total = 0;
   int bad   = 0;

   int         bits_sent = 0;
   int         mark_cnt = 0, viol_pulses = 0, overlap_cnt = 0, mark_pos = 0;
   logic [7:0] mark_byte = 8'h00;
   logic [7:0] byte_log[$];
   int         pos_log[$];
   logic       prev_d = 1'b0;

   mfm_sync_byte_assembler dut (
      .clk(clk), .reset(reset), .enable(enable), .resync(resync),
      .pll_locked(pll_locked), .bit_ready(bit_ready), .clock_bit(clock_bit),
      .data_bit(data_bit), .byte_data(byte_data), .byte_valid(byte_valid),
      .mark_valid(mark_valid), .in_frame(in_frame), .sync_count(sync_count),
      .code_violation(code_violation), .viol_count(viol_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bit_ready) bits_sent++;

   always @(negedge clk) begin
      if (mark_valid) begin mark_cnt++; mark_byte = byte_data; mark_pos = bits_sent; end
      if (byte_valid) begin byte_log.push_back(byte_data); pos_log.push_back(bits_sent); end
      if (code_violation) viol_pulses++;
      if (mark_valid && byte_valid) overlap_cnt++;
   end

   task automatic send_pair(input logic c, input logic d);
      @(negedge clk); clock_bit = c; data_bit = d; bit_ready = 1'b1;
      @(negedge clk); bit_ready = 1'b0; prev_d = d; #1;
   endtask

   task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) send_pair(!prev_d && !b[i], b[i]);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(b, 7, 0);
   endtask

   task automatic send_byte_fast(input logic [7:0] b);
      @(negedge clk);
      for (int i = 7; i >= 0; i--) begin
         clock_bit = !prev_d && !b[i]; data_bit = b[i]; bit_ready = 1'b1; prev_d = b[i];
         @(negedge clk);
      end
      bit_ready = 1'b0; #1;
   endtask

   task automatic send_raw(input logic [15:0] r);
      for (int i = 7; i >= 0; i--) send_pair(r[2*i+1], r[2*i]);
   endtask

   task automatic send_gap(input int n);
      repeat (n) send_byte(8'h4E);
   endtask

   task automatic do_resync;
      @(negedge clk); resync = 1'b1;
      @(negedge clk); resync = 1'b0; prev_d = 1'b0; #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b1; resync = 1'b0; pll_locked = 1'b1;
      bit_ready = 1'b0; clock_bit = 1'b0; data_bit = 1'b0;
      idle(3);
      total++; if (byte_data !== 8'h00) begin bad++; $display("FAIL reset_byte_data: got %h want 00", byte_data); end
      total++; if ({byte_valid, mark_valid, in_frame, code_violation} !== 4'b0000) begin bad++; $display("FAIL reset_strobes: got %b want 0000", {byte_valid, mark_valid, in_frame, code_violation}); end
      total++; if (sync_count !== 3'd0) begin bad++; $display("FAIL reset_sync_count: got %0d want 0", sync_count); end
      total++; if (viol_count !== 8'd0) begin bad++; $display("FAIL reset_viol_count: got %0d want 0", viol_count); end
      reset = 1'b0;
      idle(1);
   endtask

   task automatic test_mark;
      int m0;
      send_gap(12);
      repeat (3) send_raw(16'h4489);
      total++; if (sync_count !== 3'd3) begin bad++; $display("FAIL mark_sync3: got %0d want 3", sync_count); end
      total++; if (in_frame !== 1'b0) begin bad++; $display("FAIL mark_not_framed: got %b want 0", in_frame); end
      m0 = mark_cnt;
      send_byte(8'hFE);
      total++; if (mark_valid !== 1'b1) begin bad++; $display("FAIL mark_strobe: got %b want 1", mark_valid); end
      total++; if (byte_data !== 8'hFE) begin bad++; $display("FAIL mark_byte: got %h want fe", byte_data); end
      total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL mark_no_byte_valid: got %b want 0", byte_valid); end
      total++; if (in_frame !== 1'b1) begin bad++; $display("FAIL mark_in_frame: got %b want 1", in_frame); end
      total++; if (sync_count !== 3'd3) begin bad++; $display("FAIL mark_sync_hold: got %0d want 3", sync_count); end
      total++; if (mark_cnt - m0 != 1) begin bad++; $display("FAIL mark_count: got %0d want 1", mark_cnt - m0); end
   endtask

   task automatic test_back_to_back;
      int base;
      base = byte_log.size();
      send_byte_fast(8'h00);
      send_byte_fast(8'hFF);
      send_byte_fast(8'hA5);
      idle(2);
      total++; if (byte_log.size() - base != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", byte_log.size() - base); end
      if (byte_log.size() - base == 3) begin
         total++; if (byte_log[base] !== 8'h00) begin bad++; $display("FAIL b2b_byte0: got %h want 00", byte_log[base]); end
         total++; if (byte_log[base+1] !== 8'hFF) begin bad++; $display("FAIL b2b_byte1: got %h want ff", byte_log[base+1]); end
         total++; if (byte_log[base+2] !== 8'hA5) begin bad++; $display("FAIL b2b_byte2: got %h want a5", byte_log[base+2]); end
         total++; if (pos_log[base] - mark_pos != 8) begin bad++; $display("FAIL b2b_gap0: got %0d want 8", pos_log[base] - mark_pos); end
         total++; if (pos_log[base+1] - pos_log[base] != 8) begin bad++; $display("FAIL b2b_gap1: got %0d want 8", pos_log[base+1] - pos_log[base]); end
         total++; if (pos_log[base+2] - pos_log[base+1] != 8) begin bad++; $display("FAIL b2b_gap2: got %0d want 8", pos_log[base+2] - pos_log[base+1]); end
      end
      total++; if (byte_data !== 8'hA5) begin bad++; $display("FAIL b2b_hold: got %h want a5", byte_data); end
   endtask

   task automatic test_short_sync;
      int m0;
      do_resync;
      total++; if (in_frame !== 1'b0) begin bad++; $display("FAIL short_resync_exit: got %b want 0", in_frame); end
      send_gap(12);
      send_raw(16'h4489);
      send_raw(16'h4489);
      total++; if (sync_count !== 3'd2) begin bad++; $display("FAIL short_sync2: got %0d want 2", sync_count); end
      m0 = mark_cnt;
      send_byte(8'hFE);
      total++; if (mark_cnt != m0) begin bad++; $display("FAIL short_no_mark: got %0d want %0d", mark_cnt, m0); end
      total++; if (sync_count !== 3'd0) begin bad++; $display("FAIL short_sync_clear: got %0d want 0", sync_count); end
      total++; if (in_frame !== 1'b0) begin bad++; $display("FAIL short_hunt: got %b want 0", in_frame); end
      total++; if (byte_data !== 8'hA5) begin bad++; $display("FAIL short_byte_hold: got %h want a5", byte_data); end
   endtask

   task automatic test_pll_drop;
      int base;
      do_resync;
      send_gap(12);
      repeat (3) send_raw(16'h4489);
      send_byte(8'hFE);
      base = byte_log.size();
      send_bits(8'h5A, 7, 4);
      @(negedge clk); pll_locked = 1'b0;
      @(negedge clk); pll_locked = 1'b1; #1;
      total++; if (in_frame !== 1'b0) begin bad++; $display("FAIL pll_exit: got %b want 0", in_frame); end
      total++; if (sync_count !== 3'd0) begin bad++; $display("FAIL pll_sync_clear: got %0d want 0", sync_count); end
      send_bits(8'h5A, 3, 0);
      idle(2);
      total++; if (byte_log.size() != base) begin bad++; $display("FAIL pll_no_byte: got %0d want %0d", byte_log.size(), base); end
      send_gap(4);
      repeat (3) send_raw(16'h4489);
      send_byte(8'hFB);
      total++; if (mark_valid !== 1'b1 || byte_data !== 8'hFB) begin bad++; $display("FAIL pll_reframe_mark: got %b/%h want 1/fb", mark_valid, byte_data); end
      send_byte(8'h3C);
      total++; if (byte_valid !== 1'b1 || byte_data !== 8'h3C) begin bad++; $display("FAIL pll_reframe_byte: got %b/%h want 1/3c", byte_valid, byte_data); end
      total++; if (overlap_cnt != 0) begin bad++; $display("FAIL strobe_overlap: got %0d want 0", overlap_cnt); end
   endtask

   task automatic test_violation;
      int v0;
      do_resync;
      total++; if (viol_count !== 8'd0) begin bad++; $display("FAIL viol_none_legal: got %0d want 0", viol_count); end
      send_pair(1'b1, 1'b1);
      total++; if (code_violation !== 1'b1 || viol_count !== 8'd1) begin bad++; $display("FAIL viol_both: got %b/%0d want 1/1", code_violation, viol_count); end
      send_pair(1'b1, 1'b0);
      total++; if (code_violation !== 1'b1 || viol_count !== 8'd2) begin bad++; $display("FAIL viol_after_one: got %b/%0d want 1/2", code_violation, viol_count); end
      v0 = viol_pulses;
      send_raw(16'h4489);
      idle(1);
      total++; if (viol_pulses != v0 || viol_count !== 8'd2) begin bad++; $display("FAIL viol_sync_clean: got %0d/%0d want %0d/2", viol_pulses, viol_count, v0); end
   endtask

   task automatic test_resync_with_bit;
      int m0;
      do_resync;
      send_gap(4);
      repeat (3) send_raw(16'h4489);
      send_bits(8'hFE, 7, 4);
      m0 = mark_cnt;
      @(negedge clk); resync = 1'b1; bit_ready = 1'b1; clock_bit = 1'b0; data_bit = 1'b1;
      @(negedge clk); resync = 1'b0; bit_ready = 1'b0; prev_d = 1'b0; #1;
      total++; if (sync_count !== 3'd0 || in_frame !== 1'b0) begin bad++; $display("FAIL rsb_hunt: got %0d/%b want 0/0", sync_count, in_frame); end
      // Tail of a sync mark: only matches if stale raw history survived the resync.
      send_pair(1'b0, 1'b0); send_pair(1'b0, 1'b1); send_pair(1'b0, 1'b0); send_pair(1'b1, 1'b0);
      send_pair(1'b0, 1'b0); send_pair(1'b1, 1'b0); send_pair(1'b0, 1'b1);
      total++; if (sync_count !== 3'd0) begin bad++; $display("FAIL rsb_raw_cleared: got %0d want 0", sync_count); end
      idle(8);
      total++; if (mark_cnt != m0) begin bad++; $display("FAIL rsb_no_mark: got %0d want %0d", mark_cnt, m0); end
   endtask

   task automatic test_viol_saturate;
      repeat (253) send_pair(1'b1, 1'b1);
      total++; if (viol_count !== 8'd255) begin bad++; $display("FAIL sat_reach: got %0d want 255", viol_count); end
      send_pair(1'b1, 1'b1);
      total++; if (viol_count !== 8'd255 || code_violation !== 1'b1) begin bad++; $display("FAIL sat_hold: got %0d/%b want 255/1", viol_count, code_violation); end
   endtask

   task automatic test_reset_midframe;
      send_gap(4);
      repeat (3) send_raw(16'h4489);
      send_byte(8'hFE);
      send_bits(8'h77, 7, 5);
      total++; if (in_frame !== 1'b1) begin bad++; $display("FAIL rmid_framed: got %b want 1", in_frame); end
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0; #1;
      total++; if (in_frame !== 1'b0 || sync_count !== 3'd0) begin bad++; $display("FAIL rmid_state: got %b/%0d want 0/0", in_frame, sync_count); end
      total++; if (viol_count !== 8'd0 || byte_data !== 8'h00) begin bad++; $display("FAIL rmid_regs: got %0d/%h want 0/00", viol_count, byte_data); end
   endtask

   initial begin
      test_reset;
      test_mark;
      test_back_to_back;
      test_short_sync;
      test_pll_drop;
      test_violation;
      test_resync_with_bit;
      test_viol_saturate;
      test_reset_midframe;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
